// File: rtl/inst_fetch_pkg.sv
// Shared fetch/decode definitions: common datapath width, the canonical NOP
// and the fetch sequencer state encoding.
package inst_fetch_pkg;

    // Datapath width shared by the whole core (mirrors common_def.h).
    localparam int unsigned COMMON_WIDTH = 32;

    // Canonical NOP (addi x0, x0, 0). Decode uses the same value.
    localparam logic [COMMON_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no request outstanding
        WAIT = 2'd1,  // request accepted, response pending
        DROP = 2'd2   // flushed request pending, its response is discarded
    } fetch_state_e;

    // A fetch address is word aligned when its two low bits are zero.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_out_reg.sv
// if_out_reg: one-entry valid/ready register that holds the fetched
// {pc, instruction, misalign} tuple for decode.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           clears the entry; wins over a same-cycle load
//   load            write a new entry (caller guarantees the slot is free)
//   load_pc/inst/misalign   payload for the new entry
//   out_ready       consumer accepts the entry when out_valid is set
//   out_valid/pc/inst/misalign   registered entry presented downstream
module if_out_reg
    import inst_fetch_pkg::*;
#(
    parameter int unsigned      W        = COMMON_WIDTH,
    parameter logic [W-1:0]     NOP_WORD = W'(NOP_INST)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] load_pc,
    input  logic [W-1:0] load_inst,
    input  logic         load_misalign,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_pc,
    output logic [W-1:0] out_inst,
    output logic         out_misalign
);

    // Entry update. Whenever the entry becomes empty the instruction returns
    // to NOP so decode never sees stale bits behind a low valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_inst     <= NOP_WORD;
            out_misalign <= 1'b0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            out_inst     <= NOP_WORD;
            out_misalign <= 1'b0;
        end else if (load) begin
            out_valid    <= 1'b1;
            out_pc       <= load_pc;
            out_inst     <= load_inst;
            out_misalign <= load_misalign;
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
            out_inst     <= NOP_WORD;
            out_misalign <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage between the PC register and decode.
// Issues one memory read per PC (at most one outstanding), returns the
// instruction to decode through a one-entry output register, backpressures
// the PC register and discards in-flight fetches on flush.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   pc_addr                     current fetch PC
//   stall_req                   PC register stall; 0 = pc_addr consumed now
//   flush                       kills the output entry and in-flight fetch
//   mem_req_valid/addr/ready    instruction memory request channel
//   mem_resp_valid/data         instruction memory response
//   if_valid/pc/inst/misalign   registered entry presented to decode
//   id_ready                    decode consumes the entry
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned        XLEN     = COMMON_WIDTH,
    parameter logic [XLEN-1:0]    NOP_INST = XLEN'(inst_fetch_pkg::NOP_INST)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_addr,
    output logic            stall_req,
    input  logic            flush,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    output logic            if_misalign,
    input  logic            id_ready
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] req_pc_q;
    logic            capture_pc;

    logic            slot_free;
    logic            pc_aligned;

    logic            load;
    logic [XLEN-1:0] load_pc;
    logic [XLEN-1:0] load_inst;
    logic            load_misalign;

    assign slot_free    = !if_valid || id_ready;
    assign pc_aligned   = is_word_aligned(pc_addr[1:0]);
    assign mem_req_addr = pc_addr;

    // State and outstanding-request PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture_pc) begin
                req_pc_q <= pc_addr;
            end
        end
    end

    // Next state, request channel, PC backpressure and output-register load.
    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        stall_req     = 1'b1;
        capture_pc    = 1'b0;
        load          = 1'b0;
        load_pc       = req_pc_q;
        load_inst     = mem_resp_data;
        load_misalign = 1'b0;

        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    // A response arriving here is a protocol violation: ignored.
                    if (!flush && slot_free) begin
                        if (pc_aligned) begin
                            mem_req_valid = 1'b1;
                            if (mem_req_ready) begin
                                stall_req  = 1'b0;
                                capture_pc = 1'b1;
                                state_d    = WAIT;
                            end
                        end else begin
                            // Misaligned PC: report an exception entry without
                            // touching memory and let the PC move on.
                            stall_req     = 1'b0;
                            load          = 1'b1;
                            load_pc       = pc_addr;
                            load_inst     = NOP_INST;
                            load_misalign = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        load    = !flush;
                        state_d = IDLE;
                    end else if (flush) begin
                        state_d = DROP;
                    end
                end
                DROP: begin
                    if (mem_resp_valid) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    if_out_reg #(
        .W        (XLEN),
        .NOP_WORD (NOP_INST)
    ) u_out_reg (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .load          (load),
        .load_pc       (load_pc),
        .load_inst     (load_inst),
        .load_misalign (load_misalign),
        .out_ready     (id_ready),
        .out_valid     (if_valid),
        .out_pc        (if_pc),
        .out_inst      (if_inst),
        .out_misalign  (if_misalign)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: inputs are driven 1 ns after each rising
// edge, outputs are sampled 1 ns later, well away from the next edge.
module tb_inst_fetch;

    localparam int unsigned   XLEN = 32;
    localparam logic [31:0]   NOP  = 32'h0000_0013;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] pc_addr;
    logic            stall_req;
    logic            flush;
    logic            mem_req_valid;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_ready;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_inst;
    logic            if_misalign;
    logic            id_ready;

    int tests_run;
    int tests_failed;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .pc_addr        (pc_addr),
        .stall_req      (stall_req),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_misalign    (if_misalign),
        .id_ready       (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks all four decode-facing outputs at once.
    task automatic chk_entry(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] inst, input logic mis);
        chk1 ({tag, ".valid"}, if_valid, v);
        chk32({tag, ".pc"}, if_pc, pc);
        chk32({tag, ".inst"}, if_inst, inst);
        chk1 ({tag, ".misalign"}, if_misalign, mis);
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        pc_addr        = '0;
        flush          = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        id_ready       = 1'b1;

        // Reset state.
        tick();
        tick();
        settle();
        chk1 ("rst_req_valid", mem_req_valid, 1'b0);
        chk1 ("rst_stall", stall_req, 1'b1);
        chk_entry("rst_entry", 1'b0, 32'h0, NOP, 1'b0);

        // Basic fetch, k=1: request in cycle 1, entry visible in cycle 3.
        rst = 1'b0;
        settle();
        chk1 ("c1_req_valid", mem_req_valid, 1'b1);
        chk32("c1_req_addr", mem_req_addr, 32'h0);
        chk1 ("c1_stall", stall_req, 1'b0);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0050_0093;
        settle();
        chk1 ("c2_req_valid", mem_req_valid, 1'b0);
        chk1 ("c2_stall", stall_req, 1'b1);
        chk1 ("c2_if_valid", if_valid, 1'b0);
        tick();
        mem_resp_valid = 1'b0;
        pc_addr        = 32'h4;
        id_ready       = 1'b0;
        settle();
        chk_entry("c3_entry", 1'b1, 32'h0, 32'h0050_0093, 1'b0);

        // Decode stalled for 5 cycles: entry held, no request, PC stalled.
        for (int i = 0; i < 5; i++) begin
            chk_entry("hold_entry", 1'b1, 32'h0, 32'h0050_0093, 1'b0);
            chk1("hold_req_valid", mem_req_valid, 1'b0);
            chk1("hold_stall", stall_req, 1'b1);
            tick();
            settle();
        end

        // Decode ready again: new request in the same cycle.
        id_ready = 1'b1;
        settle();
        chk1 ("resume_req_valid", mem_req_valid, 1'b1);
        chk32("resume_req_addr", mem_req_addr, 32'h4);
        chk1 ("resume_stall", stall_req, 1'b0);
        tick();

        // Flush one cycle after acceptance; response at k=3 is discarded.
        chk1("wait_if_valid", if_valid, 1'b0);
        flush = 1'b1;
        settle();
        chk1("flush_stall", stall_req, 1'b1);
        chk1("flush_req_valid", mem_req_valid, 1'b0);
        tick();
        flush   = 1'b0;
        pc_addr = 32'h8;
        settle();
        chk1("drop1_req_valid", mem_req_valid, 1'b0);
        chk1("drop1_stall", stall_req, 1'b1);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        settle();
        chk1("drop2_req_valid", mem_req_valid, 1'b0);
        tick();
        mem_resp_valid = 1'b0;
        settle();
        chk1 ("drop_if_valid", if_valid, 1'b0);
        chk1 ("after_drop_req_valid", mem_req_valid, 1'b1);
        chk32("after_drop_req_addr", mem_req_addr, 32'h8);
        chk1 ("after_drop_stall", stall_req, 1'b0);
        tick();

        // Flush in the same cycle as the response: data dropped, back to IDLE.
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1111_2222;
        flush          = 1'b1;
        settle();
        chk1("flush_resp_stall", stall_req, 1'b1);
        tick();
        mem_resp_valid = 1'b0;
        flush          = 1'b0;
        pc_addr        = 32'h102;
        settle();
        chk1("flush_resp_if_valid", if_valid, 1'b0);

        // Misaligned PC: no memory request, exception entry next cycle.
        chk1("mis_req_valid", mem_req_valid, 1'b0);
        chk1("mis_stall", stall_req, 1'b0);
        tick();
        pc_addr = 32'h100;
        settle();
        chk_entry("mis_entry", 1'b1, 32'h102, NOP, 1'b1);
        chk1 ("mis_next_req_valid", mem_req_valid, 1'b1);
        chk32("mis_next_req_addr", mem_req_addr, 32'h100);
        tick();

        // Reset while in WAIT: back to IDLE, late response ignored.
        chk1("pre_rst_if_valid", if_valid, 1'b0);
        chk1("pre_rst_stall", stall_req, 1'b1);
        rst = 1'b1;
        settle();
        chk1("in_rst_req_valid", mem_req_valid, 1'b0);
        tick();
        rst            = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1234_5678;
        settle();
        chk_entry("post_rst_entry", 1'b0, 32'h0, NOP, 1'b0);
        chk1("post_rst_req_valid", mem_req_valid, 1'b1);
        chk1("post_rst_stall", stall_req, 1'b1);
        tick();
        mem_resp_valid = 1'b0;
        settle();
        chk1 ("late_resp_if_valid", if_valid, 1'b0);
        chk32("late_resp_if_inst", if_inst, NOP);
        chk1 ("late_resp_req_valid", mem_req_valid, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
